// File: rtl/complex_mult_pipe.sv
// Four-stage signed fixed-point complex multiplier (A*B or A*conj(B)) with
// rounding, saturation and a stall-able valid/ready handshake.
module complex_mult_pipe #(
  parameter int W     = 18,
  parameter bit ROUND = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] DinAR,
  input  logic [W-1:0] DinAI,
  input  logic [W-1:0] DinBR,
  input  logic [W-1:0] DinBI,
  input  logic         DinConj,
  input  logic         DinValid,
  output logic         DinReady,
  output logic [W-1:0] DoutR,
  output logic [W-1:0] DoutI,
  output logic         DoutOvf,
  output logic         DoutValid,
  input  logic         DoutReady,
  output logic         OvfSticky
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;
  localparam int XW = 2 * W + 2;

  localparam logic signed [XW-1:0] ROUND_BIAS = ROUND ? (XW'(1) << (W - 2)) : '0;
  localparam logic signed [XW-1:0] SAT_MAX    = (XW'(1) << (W - 1)) - XW'(1);
  localparam logic signed [XW-1:0] SAT_MIN    = -(XW'(1) << (W - 1));

  logic advance;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_conj_q, s1_conj_d;
  logic signed [W-1:0]  s1_ar_q, s1_ar_d;
  logic signed [W-1:0]  s1_ai_q, s1_ai_d;
  logic signed [W-1:0]  s1_br_q, s1_br_d;
  logic signed [W-1:0]  s1_bi_q, s1_bi_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_conj_q, s2_conj_d;
  logic signed [PW-1:0] s2_rr_q, s2_rr_d;
  logic signed [PW-1:0] s2_ii_q, s2_ii_d;
  logic signed [PW-1:0] s2_ri_q, s2_ri_d;
  logic signed [PW-1:0] s2_ir_q, s2_ir_d;

  logic                 s3_valid_q, s3_valid_d;
  logic signed [SW-1:0] s3_re_q, s3_re_d;
  logic signed [SW-1:0] s3_im_q, s3_im_d;

  logic                 dout_valid_q, dout_valid_d;
  logic [W-1:0]         dout_r_q, dout_r_d;
  logic [W-1:0]         dout_i_q, dout_i_d;
  logic                 dout_ovf_q, dout_ovf_d;
  logic                 ovf_sticky_q, ovf_sticky_d;

  logic signed [XW-1:0] rnd_re, rnd_im;
  logic signed [XW-1:0] shf_re, shf_im;
  logic [W-1:0]         sat_re, sat_im;
  logic                 ovf_re, ovf_im;

  // A single global enable: the whole pipe moves only when the output slot frees up.
  assign advance  = !dout_valid_q || DoutReady;
  assign DinReady = advance;

  assign DoutR     = dout_r_q;
  assign DoutI     = dout_i_q;
  assign DoutOvf   = dout_ovf_q;
  assign DoutValid = dout_valid_q;
  assign OvfSticky = ovf_sticky_q;

  always_comb begin
    rnd_re = XW'(s3_re_q) + ROUND_BIAS;
    rnd_im = XW'(s3_im_q) + ROUND_BIAS;
    shf_re = rnd_re >>> (W - 1);
    shf_im = rnd_im >>> (W - 1);

    sat_re = shf_re[W-1:0];
    ovf_re = 1'b0;
    if (shf_re > SAT_MAX) begin
      sat_re = SAT_MAX[W-1:0];
      ovf_re = 1'b1;
    end else if (shf_re < SAT_MIN) begin
      sat_re = SAT_MIN[W-1:0];
      ovf_re = 1'b1;
    end

    sat_im = shf_im[W-1:0];
    ovf_im = 1'b0;
    if (shf_im > SAT_MAX) begin
      sat_im = SAT_MAX[W-1:0];
      ovf_im = 1'b1;
    end else if (shf_im < SAT_MIN) begin
      sat_im = SAT_MIN[W-1:0];
      ovf_im = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_conj_d    = s1_conj_q;
    s1_ar_d      = s1_ar_q;
    s1_ai_d      = s1_ai_q;
    s1_br_d      = s1_br_q;
    s1_bi_d      = s1_bi_q;
    s2_valid_d   = s2_valid_q;
    s2_conj_d    = s2_conj_q;
    s2_rr_d      = s2_rr_q;
    s2_ii_d      = s2_ii_q;
    s2_ri_d      = s2_ri_q;
    s2_ir_d      = s2_ir_q;
    s3_valid_d   = s3_valid_q;
    s3_re_d      = s3_re_q;
    s3_im_d      = s3_im_q;
    dout_valid_d = dout_valid_q;
    dout_r_d     = dout_r_q;
    dout_i_d     = dout_i_q;
    dout_ovf_d   = dout_ovf_q;

    if (advance) begin
      s1_valid_d   = DinValid;
      s1_conj_d    = DinConj;
      s1_ar_d      = DinAR;
      s1_ai_d      = DinAI;
      s1_br_d      = DinBR;
      s1_bi_d      = DinBI;

      s2_valid_d   = s1_valid_q;
      s2_conj_d    = s1_conj_q;
      s2_rr_d      = s1_ar_q * s1_br_q;
      s2_ii_d      = s1_ai_q * s1_bi_q;
      s2_ri_d      = s1_ar_q * s1_bi_q;
      s2_ir_d      = s1_ai_q * s1_br_q;

      // Conjugating B only flips the sign of BI, i.e. of the ii and ri terms.
      s3_valid_d   = s2_valid_q;
      s3_re_d      = s2_conj_q ? (s2_rr_q + s2_ii_q) : (s2_rr_q - s2_ii_q);
      s3_im_d      = s2_conj_q ? (s2_ir_q - s2_ri_q) : (s2_ri_q + s2_ir_q);

      dout_valid_d = s3_valid_q;
      dout_r_d     = sat_re;
      dout_i_d     = sat_im;
      dout_ovf_d   = ovf_re | ovf_im;
    end

    ovf_sticky_d = ovf_sticky_q | (dout_valid_q & DoutReady & dout_ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_r_q     <= '0;
      dout_i_q     <= '0;
      dout_ovf_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s3_valid_q   <= s3_valid_d;
      dout_valid_q <= dout_valid_d;
      dout_r_q     <= dout_r_d;
      dout_i_q     <= dout_i_d;
      dout_ovf_q   <= dout_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Datapath registers need no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    s1_conj_q <= s1_conj_d;
    s1_ar_q   <= s1_ar_d;
    s1_ai_q   <= s1_ai_d;
    s1_br_q   <= s1_br_d;
    s1_bi_q   <= s1_bi_d;
    s2_conj_q <= s2_conj_d;
    s2_rr_q   <= s2_rr_d;
    s2_ii_q   <= s2_ii_d;
    s2_ri_q   <= s2_ri_d;
    s2_ir_q   <= s2_ir_d;
    s3_re_q   <= s3_re_d;
    s3_im_q   <= s3_im_d;
  end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed and streaming bench for complex_mult_pipe at W=18, with a ROUND=1
// instance and a ROUND=0 twin sharing the same stimulus.
module tb_complex_mult_pipe;

  logic        clk;
  logic        rst;
  logic [17:0] DinAR, DinAI, DinBR, DinBI;
  logic        DinConj, DinValid, DinReady;
  logic [17:0] DoutR, DoutI;
  logic        DoutOvf, DoutValid, DoutReady, OvfSticky;

  logic        t_DinReady;
  logic [17:0] t_DoutR, t_DoutI;
  logic        t_DoutOvf, t_DoutValid, t_OvfSticky;

  int checks;
  int errors;

  complex_mult_pipe #(.W(18), .ROUND(1'b1)) dut (
    .clk(clk), .rst(rst),
    .DinAR(DinAR), .DinAI(DinAI), .DinBR(DinBR), .DinBI(DinBI),
    .DinConj(DinConj), .DinValid(DinValid), .DinReady(DinReady),
    .DoutR(DoutR), .DoutI(DoutI), .DoutOvf(DoutOvf), .DoutValid(DoutValid),
    .DoutReady(DoutReady), .OvfSticky(OvfSticky)
  );

  complex_mult_pipe #(.W(18), .ROUND(1'b0)) dut_trunc (
    .clk(clk), .rst(rst),
    .DinAR(DinAR), .DinAI(DinAI), .DinBR(DinBR), .DinBI(DinBI),
    .DinConj(DinConj), .DinValid(DinValid), .DinReady(t_DinReady),
    .DoutR(t_DoutR), .DoutI(t_DoutI), .DoutOvf(t_DoutOvf), .DoutValid(t_DoutValid),
    .DoutReady(DoutReady), .OvfSticky(t_OvfSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on 64-bit integers, rounding enabled.
  function automatic void model(input logic [17:0] ar, ai, br, bi, input logic conj,
                                output logic [17:0] r, i, output logic ovf);
    longint a_r, a_i, b_r, b_i, re, im;
    a_r = longint'($signed(ar));
    a_i = longint'($signed(ai));
    b_r = longint'($signed(br));
    b_i = longint'($signed(bi));
    if (conj) begin
      re = a_r * b_r + a_i * b_i;
      im = a_i * b_r - a_r * b_i;
    end else begin
      re = a_r * b_r - a_i * b_i;
      im = a_r * b_i + a_i * b_r;
    end
    re = (re + 65536) >>> 17;
    im = (im + 65536) >>> 17;
    ovf = 1'b0;
    if (re > 131071) begin re = 131071; ovf = 1'b1; end
    if (re < -131072) begin re = -131072; ovf = 1'b1; end
    if (im > 131071) begin im = 131071; ovf = 1'b1; end
    if (im < -131072) begin im = -131072; ovf = 1'b1; end
    r = re[17:0];
    i = im[17:0];
  endfunction

  // Sends one sample with DoutReady=1 and returns the first valid result and
  // the number of rising edges from the accepting edge to DoutValid.
  task automatic run_single(input logic [17:0] ar, ai, br, bi, input logic conj,
                            output logic [17:0] r, i, output logic ovf,
                            output logic [17:0] r_t, output int lat);
    DinAR = ar; DinAI = ai; DinBR = br; DinBI = bi; DinConj = conj;
    DinValid = 1'b1;
    DoutReady = 1'b1;
    lat = -1;
    r = '0; i = '0; ovf = 1'b0; r_t = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) DinValid = 1'b0;
      if (DoutValid) begin
        lat = k;
        r = DoutR; i = DoutI; ovf = DoutOvf; r_t = t_DoutR;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; DinValid = 1'b0; DoutReady = 1'b1; DinConj = 1'b0;
    DinAR = '0; DinAI = '0; DinBR = '0; DinBI = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (DoutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", DoutValid); end
    checks++; if (DoutR !== 18'd0 || DoutI !== 18'd0) begin errors++; $display("[TB] FAIL reset_data got %0d/%0d want 0/0", DoutR, DoutI); end
    checks++; if (DoutOvf !== 1'b0 || OvfSticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b/%b want 0/0", DoutOvf, OvfSticky); end
    checks++; if (DinReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", DinReady); end
  endtask

  task automatic test_normal();
    logic [17:0] r, i, r_t; logic ovf; int lat;
    run_single(18'd65536, 18'd65536, 18'd65536, -18'sd65536, 1'b0, r, i, ovf, r_t, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL normal_latency got %0d want 4", lat); end
    checks++; if (r !== 18'd65536 || i !== 18'd0 || ovf !== 1'b0)
      begin errors++; $display("[TB] FAIL normal_result got %0d/%0d ovf %b want 65536/0 ovf 0", r, i, ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_conj();
    logic [17:0] r, i, r_t; logic ovf; int lat;
    run_single(18'd65536, 18'd65536, 18'd65536, -18'sd65536, 1'b1, r, i, ovf, r_t, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL conj_latency got %0d want 4", lat); end
    checks++; if (r !== 18'd0 || i !== 18'd65536 || ovf !== 1'b0)
      begin errors++; $display("[TB] FAIL conj_result got %0d/%0d ovf %b want 0/65536 ovf 0", r, i, ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    logic [17:0] r, i, r_t; logic ovf; int lat;
    run_single(18'h20000, 18'd0, 18'h20000, 18'd0, 1'b0, r, i, ovf, r_t, lat);
    checks++; if (r !== 18'd131071 || i !== 18'd0 || ovf !== 1'b1)
      begin errors++; $display("[TB] FAIL ovf_m1m1 got %0d/%0d ovf %b want 131071/0 ovf 1", r, i, ovf); end
    checks++; if (OvfSticky !== 1'b0) begin errors++; $display("[TB] FAIL sticky_before_xfer got %b want 0", OvfSticky); end
    @(posedge clk); #1;
    checks++; if (OvfSticky !== 1'b1) begin errors++; $display("[TB] FAIL sticky_after_xfer got %b want 1", OvfSticky); end
    run_single(18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b0, r, i, ovf, r_t, lat);
    checks++; if (r !== 18'd0 || i !== 18'd131071 || ovf !== 1'b1)
      begin errors++; $display("[TB] FAIL ovf_sum got %0d/%0d ovf %b want 0/131071 ovf 1", r, i, ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    logic [17:0] r, i, r_t; logic ovf; int lat;
    run_single(18'd1, 18'd0, 18'd65536, 18'd0, 1'b0, r, i, ovf, r_t, lat);
    checks++; if (r !== 18'd1) begin errors++; $display("[TB] FAIL round_pos got %0d want 1", r); end
    checks++; if (r_t !== 18'd0) begin errors++; $display("[TB] FAIL trunc_pos got %0d want 0", r_t); end
    @(posedge clk); #1;
    run_single(18'h3FFFF, 18'd0, 18'd65536, 18'd0, 1'b0, r, i, ovf, r_t, lat);
    checks++; if (r !== 18'd0) begin errors++; $display("[TB] FAIL round_neg got %0d want 0", r); end
    checks++; if (r_t !== 18'h3FFFF) begin errors++; $display("[TB] FAIL trunc_neg got %0d want 262143", r_t); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_r [3];
    logic [17:0] exp_i [3];
    int seen, first_k;
    exp_r[0] = 18'd65536; exp_i[0] = 18'd0;
    exp_r[1] = 18'd0;     exp_i[1] = 18'd65536;
    exp_r[2] = 18'd1;     exp_i[2] = 18'd0;
    seen = 0; first_k = -1;
    DoutReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      DinValid = (k < 3);
      DinAR = (k == 2) ? 18'd1 : 18'd65536;
      DinAI = (k == 2) ? 18'd0 : 18'd65536;
      DinBR = 18'd65536;
      DinBI = (k == 2) ? 18'd0 : -18'sd65536;
      DinConj = (k == 1);
      @(posedge clk); #1;
      if (DoutValid && seen < 3) begin
        if (first_k < 0) first_k = k;
        checks++;
        if (DoutR !== exp_r[seen] || DoutI !== exp_i[seen] || k !== first_k + seen) begin
          errors++;
          $display("[TB] FAIL b2b_%0d got %0d/%0d at %0d want %0d/%0d at %0d",
                   seen, DoutR, DoutI, k, exp_r[seen], exp_i[seen], first_k + seen);
        end
        seen++;
      end
    end
    DinValid = 1'b0; DinConj = 1'b0;
    checks++; if (seen !== 3) begin errors++; $display("[TB] FAIL b2b_count got %0d want 3", seen); end
  endtask

  task automatic test_stream();
    logic [17:0] qr[$], qi[$];
    logic        qo[$];
    logic [17:0] car, cai, cbr, cbi, er, ei;
    logic        cconj, eo, acc, xfer;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    car = 18'($urandom); cai = 18'h20000; cbr = 18'($urandom); cbi = 18'($urandom);
    cconj = 1'($urandom);
    while (got < 10 && cyc < 300) begin
      cyc++;
      DinValid = (sent < 10) && ($urandom_range(0, 3) != 0);
      DinAR = car; DinAI = cai; DinBR = cbr; DinBI = cbi; DinConj = cconj;
      DoutReady = 1'($urandom_range(0, 1));
      #1;
      acc  = DinValid && DinReady;
      xfer = DoutValid && DoutReady;
      if (DoutValid) begin
        checks++;
        if (qr.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_spurious got %0d/%0d want no output", DoutR, DoutI);
        end else if (DoutR !== qr[0] || DoutI !== qi[0] || DoutOvf !== qo[0]) begin
          errors++;
          $display("[TB] FAIL stream_%0d got %0d/%0d ovf %b want %0d/%0d ovf %b",
                   got, DoutR, DoutI, DoutOvf, qr[0], qi[0], qo[0]);
        end
      end
      if (xfer && qr.size() != 0) begin
        void'(qr.pop_front()); void'(qi.pop_front()); void'(qo.pop_front());
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        model(car, cai, cbr, cbi, cconj, er, ei, eo);
        qr.push_back(er); qi.push_back(ei); qo.push_back(eo);
        sent++;
        car = ($urandom_range(0, 5) == 0) ? 18'h20000 : 18'($urandom);
        cai = 18'($urandom);
        cbr = ($urandom_range(0, 5) == 0) ? 18'h20000 : 18'($urandom);
        cbi = 18'($urandom);
        cconj = 1'($urandom);
      end
    end
    DinValid = 1'b0;
    checks++; if (got !== 10) begin errors++; $display("[TB] FAIL stream_count got %0d want 10", got); end
    DoutReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++; if (DoutValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_dup got %b want 0", DoutValid); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [17:0] r, i, r_t; logic ovf; int lat;
    checks++; if (OvfSticky !== 1'b1) begin errors++; $display("[TB] FAIL sticky_pre_reset got %b want 1", OvfSticky); end
    DoutReady = 1'b1;
    DinAR = 18'h20000; DinAI = 18'd0; DinBR = 18'h20000; DinBI = 18'd0; DinConj = 1'b0;
    DinValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (DoutValid !== 1'b0) begin errors++; $display("[TB] FAIL inflight_valid got %b want 0", DoutValid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    DinValid = 1'b0;
    checks++;
    if (dut.s1_valid_q !== 1'b0 || dut.s2_valid_q !== 1'b0 || dut.s3_valid_q !== 1'b0 || DoutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_valids got %b%b%b%b want 0000",
               dut.s1_valid_q, dut.s2_valid_q, dut.s3_valid_q, DoutValid);
    end
    checks++; if (OvfSticky !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sticky got %b want 0", OvfSticky); end
    checks++; if (DinReady !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", DinReady); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++; if (DoutValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale got %b want 0", DoutValid); end
    end
    run_single(18'd65536, 18'd65536, 18'd65536, -18'sd65536, 1'b0, r, i, ovf, r_t, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL midrst_latency got %0d want 4", lat); end
    checks++; if (r !== 18'd65536 || i !== 18'd0 || ovf !== 1'b0)
      begin errors++; $display("[TB] FAIL midrst_result got %0d/%0d ovf %b want 65536/0 ovf 0", r, i, ovf); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal();
    test_conj();
    test_ovf();
    test_rounding();
    test_back_to_back();
    test_stream();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
